// File: rtl/hazard_pkg.sv
// Shared types for the hazard control unit: FSM states, hazard-class encodings and the r0 constant.
// The hazard classes are also what the optional HAZARD_PERF_EN counters key on.
package hazard_pkg;

   typedef enum logic [1:0] {RUN, MEMWAIT, HALT} hz_state_t;

   typedef enum logic [2:0] {
      HZ_NONE,
      HZ_LOADUSE,
      HZ_FLUSH,
      HZ_FREEZE,
      HZ_HALT
   } hz_class_t;

   localparam int REG_ZERO = 0;

   function automatic logic counts_as_stall(hz_class_t c);
      return (c == HZ_LOADUSE) || (c == HZ_FREEZE);
   endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Hazard inputs and pipeline enables between the 5-stage core and its hazard control unit.
// HAZARD_PERF_EN adds the stallcycles/flushcount performance outputs.
interface hazard_control_unit_if #(
   parameter int REGADDR_W = 4
`ifdef HAZARD_PERF_EN
   , parameter int PERF_W = 16
`endif
);

   logic                 idexmemread;
   logic [REGADDR_W-1:0] idexregrd;
   logic [REGADDR_W-1:0] ifidregrs;
   logic [REGADDR_W-1:0] ifidregrt;
   logic                 branchtaken;
   logic                 memreq;
   logic                 memready;
   logic                 pcwrite;
   logic                 ifidwrite;
   logic                 ifidflush;
   logic                 idexwrite;
   logic                 idexflush;
   logic                 exmemwrite;
   logic                 memwbbubble;
   logic                 memerror;
`ifdef HAZARD_PERF_EN
   logic [PERF_W-1:0]    stallcycles;
   logic [PERF_W-1:0]    flushcount;
`endif

   modport master (
      output idexmemread, idexregrd, ifidregrs, ifidregrt, branchtaken, memreq, memready,
      input  pcwrite, ifidwrite, ifidflush, idexwrite, idexflush, exmemwrite, memwbbubble, memerror
`ifdef HAZARD_PERF_EN
      , input stallcycles, flushcount
`endif
   );

   modport slave (
      input  idexmemread, idexregrd, ifidregrs, ifidregrt, branchtaken, memreq, memready,
      output pcwrite, ifidwrite, ifidflush, idexwrite, idexflush, exmemwrite, memwbbubble, memerror
`ifdef HAZARD_PERF_EN
      , output stallcycles, flushcount
`endif
   );

endinterface

// File: rtl/hazard_perf_ctr.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module hazard_perf_ctr #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (clr) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush/freeze sequencing for the 5-stage pipeline with a bounded data-memory wait FSM.
// Optional build macro HAZARD_PERF_EN adds saturating stall-cycle and flush counters.
module hazard_control_unit
   import hazard_pkg::*;
#(
   parameter int REGADDR_W   = 4,
   parameter int MEM_TIMEOUT = 64
`ifdef HAZARD_PERF_EN
   , parameter int PERF_W    = 16
`endif
) (
   input logic               clk,
   input logic               rst,
   hazard_control_unit_if.slave hz
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   hz_state_t         state;
   logic [WAIT_W-1:0] waitcnt;
   hz_class_t         hz_class;
   logic              freeze;
   logic              loaduse;

   assign freeze  = hz.memreq & ~hz.memready;
   assign loaduse = hz.idexmemread
                  & (hz.idexregrd != REGADDR_W'(REG_ZERO))
                  & ((hz.idexregrd == hz.ifidregrs) | (hz.idexregrd == hz.ifidregrt));

   // One winning hazard class per cycle; the if-chain order is the priority order.
   always_comb begin
      hz_class = HZ_NONE;
      if (rst) begin
         hz_class = HZ_NONE;
      end else if (state == HALT) begin
         hz_class = HZ_HALT;
      end else if (freeze) begin
         hz_class = HZ_FREEZE;
      end else if (hz.branchtaken) begin
         hz_class = HZ_FLUSH;
      end else if (loaduse) begin
         hz_class = HZ_LOADUSE;
      end
   end

   always_comb begin
      hz.pcwrite     = 1'b1;
      hz.ifidwrite   = 1'b1;
      hz.ifidflush   = 1'b0;
      hz.idexwrite   = 1'b1;
      hz.idexflush   = 1'b0;
      hz.exmemwrite  = 1'b1;
      hz.memwbbubble = 1'b0;
      hz.memerror    = 1'b0;
      case (hz_class)
         HZ_HALT: begin
            hz.pcwrite     = 1'b0;
            hz.ifidwrite   = 1'b0;
            hz.idexwrite   = 1'b0;
            hz.exmemwrite  = 1'b0;
            hz.memwbbubble = 1'b1;
            hz.memerror    = 1'b1;
         end
         HZ_FREEZE: begin
            hz.pcwrite     = 1'b0;
            hz.ifidwrite   = 1'b0;
            hz.idexwrite   = 1'b0;
            hz.exmemwrite  = 1'b0;
            hz.memwbbubble = 1'b1;
         end
         HZ_FLUSH: begin
            hz.ifidflush = 1'b1;
            hz.idexflush = 1'b1;
         end
         HZ_LOADUSE: begin
            hz.pcwrite   = 1'b0;
            hz.ifidwrite = 1'b0;
            hz.idexflush = 1'b1;
         end
         default: ;
      endcase
   end

   // waitcnt counts consecutive not-ready cycles, including the one that entered MEMWAIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= RUN;
         waitcnt <= '0;
      end else begin
         case (state)
            RUN: begin
               if (freeze) begin
                  state   <= MEMWAIT;
                  waitcnt <= WAIT_W'(1);
               end
            end
            MEMWAIT: begin
               if (!hz.memreq || hz.memready) begin
                  state   <= RUN;
                  waitcnt <= '0;
               end else if (waitcnt == WAIT_LAST) begin
                  state <= HALT;
               end else begin
                  waitcnt <= waitcnt + 1'b1;
               end
            end
            HALT: state <= HALT;
            default: begin
               state   <= RUN;
               waitcnt <= '0;
            end
         endcase
      end
   end

`ifdef HAZARD_PERF_EN
   logic [PERF_W-1:0] stall_count;
   logic [PERF_W-1:0] flush_count;

   hazard_perf_ctr #(.W(PERF_W)) u_stall_ctr (
      .clk   (clk),
      .clr   (rst),
      .inc   (counts_as_stall(hz_class)),
      .count (stall_count)
   );

   hazard_perf_ctr #(.W(PERF_W)) u_flush_ctr (
      .clk   (clk),
      .clr   (rst),
      .inc   (hz_class == HZ_FLUSH),
      .count (flush_count)
   );

   assign hz.stallcycles = stall_count;
   assign hz.flushcount  = flush_count;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: driver pushes model predictions, negedge monitor compares.
// Build with HAZARD_PERF_EN defined to also check the performance counters.
module tb_hazard_control_unit;

   localparam int TIMEOUT = 4;
   localparam int PW      = 4;
   localparam int RAND_CYCLES = 3000;

   typedef struct packed {
      logic [7:0]    ctl;
      logic [PW-1:0] stall;
      logic [PW-1:0] flush;
      logic          chkPerf;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   hazard_control_unit_if #(
      .REGADDR_W(4)
`ifdef HAZARD_PERF_EN
      , .PERF_W(PW)
`endif
   ) hz ();

   hazard_control_unit #(
      .REGADDR_W(4),
      .MEM_TIMEOUT(TIMEOUT)
`ifdef HAZARD_PERF_EN
      , .PERF_W(PW)
`endif
   ) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   always #5 clk = ~clk;

   exp_t expQ[$];
   int   checks   = 0;
   int   failures = 0;
   int   cycleNo  = 0;

   // Reference model: consecutive not-ready count, halted flag, event totals.
   int waits     = 0;
   bit halted    = 1'b0;
   int stallM    = 0;
   int flushM    = 0;
   bit perfKnown = 1'b0;

   task automatic applyStimulus(input logic r, input logic ld, input logic [3:0] rd,
                                input logic [3:0] rs, input logic [3:0] rt,
                                input logic br, input logic mq, input logic mr);
      logic pw, iw, ifl, xw, xfl, ew, bub, err, fr, lu;
      exp_t e;
      @(posedge clk);
      #1;
      rst            = r;
      hz.idexmemread = ld;
      hz.idexregrd   = rd;
      hz.ifidregrs   = rs;
      hz.ifidregrt   = rt;
      hz.branchtaken = br;
      hz.memreq      = mq;
      hz.memready    = mr;

      fr = mq && !mr;
      lu = ld && (rd != 4'd0) && ((rd == rs) || (rd == rt));
      pw = 1; iw = 1; ifl = 0; xw = 1; xfl = 0; ew = 1; bub = 0; err = 0;
      if (!r) begin
         if (halted) begin
            pw = 0; iw = 0; xw = 0; ew = 0; bub = 1; err = 1;
         end else if (fr) begin
            pw = 0; iw = 0; xw = 0; ew = 0; bub = 1;
         end else if (br) begin
            ifl = 1; xfl = 1;
         end else if (lu) begin
            pw = 0; iw = 0; xfl = 1;
         end
      end
      e.ctl     = {pw, iw, ifl, xw, xfl, ew, bub, err};
      e.stall   = PW'(stallM);
      e.flush   = PW'(flushM);
      e.chkPerf = perfKnown;
      expQ.push_back(e);

      if (r) begin
         halted = 0; waits = 0; stallM = 0; flushM = 0; perfKnown = 1;
      end else if (!halted) begin
         if ((fr || (lu && !br)) && stallM < (1 << PW) - 1) stallM++;
         if (br && !fr && flushM < (1 << PW) - 1) flushM++;
         if (fr) begin
            waits++;
            if (waits >= TIMEOUT) halted = 1;
         end else begin
            waits = 0;
         end
      end
   endtask

   task automatic checkOutput(input exp_t e);
      logic [7:0] act;
      act = {hz.pcwrite, hz.ifidwrite, hz.ifidflush, hz.idexwrite,
             hz.idexflush, hz.exmemwrite, hz.memwbbubble, hz.memerror};
      checks++;
      if (act !== e.ctl) begin
         failures++;
         $display("[TB] FAIL ctl cycle %0d: got %b expected %b", cycleNo, act, e.ctl);
      end
`ifdef HAZARD_PERF_EN
      if (e.chkPerf) begin
         checks++;
         if (hz.stallcycles !== e.stall) begin
            failures++;
            $display("[TB] FAIL stallcycles cycle %0d: got %0d expected %0d", cycleNo, hz.stallcycles, e.stall);
         end
         checks++;
         if (hz.flushcount !== e.flush) begin
            failures++;
            $display("[TB] FAIL flushcount cycle %0d: got %0d expected %0d", cycleNo, hz.flushcount, e.flush);
         end
      end
`endif
   endtask

   // Monitor: every cycle the DUT presents outputs, pop one prediction and compare.
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         checkOutput(expQ.pop_front());
         cycleNo++;
      end
   end

   initial begin
      hz.idexmemread = 0; hz.idexregrd = 0; hz.ifidregrs = 0; hz.ifidregrt = 0;
      hz.branchtaken = 0; hz.memreq = 0; hz.memready = 0;

      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      // load-use: one stall, then load has left EX
      applyStimulus(0, 1, 5, 5, 1, 0, 0, 0);
      applyStimulus(0, 0, 2, 5, 1, 0, 0, 0);
      applyStimulus(0, 1, 5, 2, 5, 0, 0, 0);
      // r0 and non-matching registers never stall
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 5, 3, 4, 0, 0, 0);
      // branch wins over load-use
      applyStimulus(0, 1, 5, 5, 1, 1, 0, 0);
      // zero-wait access then a 3-cycle wait and release
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
      repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
      applyStimulus(0, 1, 5, 5, 0, 0, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
      // timeout into HALT, held against branch/load-use, then reset
      repeat (TIMEOUT) applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
      applyStimulus(0, 1, 5, 5, 0, 1, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      // reset mid-wait clears the wait count
      repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (TIMEOUT - 1) applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
      // abandoned access: memreq drops while waiting
      repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
      // branch flushes to exercise counter saturation
      repeat (20) applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);

      for (int i = 0; i < RAND_CYCLES; i++) begin
         applyStimulus(1'($urandom_range(0, 63) == 0),
                       1'($urandom_range(0, 1)),
                       4'($urandom_range(0, 3)),
                       4'($urandom_range(0, 3)),
                       4'($urandom_range(0, 3)),
                       1'($urandom_range(0, 5) == 0),
                       1'($urandom_range(0, 3) != 0),
                       1'($urandom_range(0, 1)));
      end

      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", expQ.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
